// File: rtl/decode_pkg.sv
// Shared RV32 decode definitions: opcode and func7 constants, the immediate
// format enum, and helpers that say which register fields a format uses.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R,
        FMT_NONE
    } fmt_e;

    function automatic logic uses_rs1(input fmt_e fmt);
        return (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
    endfunction

    function automatic logic uses_rs2(input fmt_e fmt);
        return (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
    endfunction

    function automatic logic uses_rd(input fmt_e fmt);
        return (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J) || (fmt == FMT_R);
    endfunction

endpackage

// File: rtl/decode_pipe_imm_gen.sv
// Immediate generator: sign-extended immediate from the instruction body
// for the given format. Opcode bits are not needed, so only [31:7] come in.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7] ins,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    // Select and sign-extend the immediate bit fields by format
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'b0};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_pipe.sv
// Single-stage RV32 decode slice: combinational decode of the fetched
// instruction captured into one valid/ready output register.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit EN_M     = 1'b0,
    parameter bit EN_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ins_i,
    input  logic [ADDR_W-1:0] ins_addr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       ins_o,
    output logic [ADDR_W-1:0] ins_addr_o,
    output logic [4:0]        rs1_addr_o,
    output logic [4:0]        rs2_addr_o,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       imm_o,
    output logic              rd_we_o,
    output logic              illegal_o
);

    logic [6:0]  opcode;
    logic [6:0]  func7;
    fmt_e        fmt_raw;
    fmt_e        fmt_d;
    logic        opc_known;
    logic        func7_ok;
    logic        illegal_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;
    logic [31:0] imm_d;
    logic        flush_eff;
    logic        accept;

    assign opcode = ins_i[6:0];
    assign func7  = ins_i[31:25];

    // Map opcode to immediate format; unknown opcodes are flagged
    always_comb begin
        fmt_raw   = FMT_NONE;
        opc_known = 1'b1;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt_raw = FMT_I;
            OPC_STORE:                                  fmt_raw = FMT_S;
            OPC_BRANCH:                                 fmt_raw = FMT_B;
            OPC_LUI, OPC_AUIPC:                         fmt_raw = FMT_U;
            OPC_JAL:                                    fmt_raw = FMT_J;
            OPC_OP:                                     fmt_raw = FMT_R;
            OPC_MISC_MEM:                               fmt_raw = FMT_NONE;
            default:                                    opc_known = 1'b0;
        endcase
    end

    // Legality check; an illegal word decodes as FMT_NONE so every field zeroes
    always_comb begin
        func7_ok  = (func7 == F7_BASE) || (func7 == F7_ALT) ||
                    (EN_M && (func7 == F7_MULDIV));
        illegal_d = (ins_i[1:0] != 2'b11) || !opc_known ||
                    ((opcode == OPC_OP) && !func7_ok);
        fmt_d     = illegal_d ? FMT_NONE : fmt_raw;
    end

    // Register indices, zeroed where the format does not use them
    always_comb begin
        rs1_d = uses_rs1(fmt_d) ? ins_i[19:15] : 5'd0;
        rs2_d = uses_rs2(fmt_d) ? ins_i[24:20] : 5'd0;
        rd_d  = uses_rd(fmt_d)  ? ins_i[11:7]  : 5'd0;
    end

    imm_gen u_imm_gen (
        .ins (ins_i[31:7]),
        .fmt (fmt_d),
        .imm (imm_d)
    );

    assign flush_eff = EN_FLUSH ? flush_i : 1'b0;
    assign ready_o   = !valid_o || ready_i;
    assign accept    = valid_i && ready_o && !flush_eff;

    // Output slice: flush beats accept; an idle transfer only clears valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            ins_o      <= '0;
            ins_addr_o <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            imm_o      <= '0;
            rd_we_o    <= 1'b0;
            illegal_o  <= 1'b0;
        end else if (flush_eff) begin
            valid_o    <= 1'b0;
        end else if (accept) begin
            valid_o    <= 1'b1;
            ins_o      <= ins_i;
            ins_addr_o <= ins_addr_i;
            rs1_addr_o <= rs1_d;
            rs2_addr_o <= rs2_d;
            rd_addr_o  <= rd_d;
            imm_o      <= imm_d;
            rd_we_o    <= (rd_d != 5'd0);
            illegal_o  <= illegal_d;
        end else if (ready_i) begin
            valid_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed vector table, hand-written handshake,
// flush and reset sequences, then randomized traffic against a reference model.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ins_i = '0;
    logic [31:0] ins_addr_i = '0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_i = 1'b0;

    logic        ready_o, valid_o, rd_we_o, illegal_o;
    logic [31:0] ins_o, ins_addr_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;

    logic        m1_ready_o, m1_valid_o, m1_rd_we_o, m1_illegal_o;
    logic [31:0] m1_ins_o, m1_ins_addr_o, m1_imm_o;
    logic [4:0]  m1_rs1_addr_o, m1_rs2_addr_o, m1_rd_addr_o;

    always #5 clk = ~clk;

    decode_pipe #(.ADDR_W(32), .EN_M(1'b0), .EN_FLUSH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .ins_o(ins_o),
        .ins_addr_o(ins_addr_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .imm_o(imm_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
    );

    decode_pipe #(.ADDR_W(32), .EN_M(1'b1), .EN_FLUSH(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .valid_i(valid_i), .ready_o(m1_ready_o), .flush_i(flush_i),
        .valid_o(m1_valid_o), .ready_i(ready_i), .ins_o(m1_ins_o),
        .ins_addr_o(m1_ins_addr_o), .rs1_addr_o(m1_rs1_addr_o), .rs2_addr_o(m1_rs2_addr_o),
        .rd_addr_o(m1_rd_addr_o), .imm_o(m1_imm_o), .rd_we_o(m1_rd_we_o), .illegal_o(m1_illegal_o)
    );

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } fld_t;

    typedef struct packed {
        logic [31:0] ins;
        fld_t        e0;
        fld_t        e1;
    } vec_t;

    fld_t got0, got1;
    assign got0 = {rs1_addr_o, rs2_addr_o, rd_addr_o, imm_o, rd_we_o, illegal_o};
    assign got1 = {m1_rs1_addr_o, m1_rs2_addr_o, m1_rd_addr_o, m1_imm_o, m1_rd_we_o, m1_illegal_o};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_fld(input string tag, input fld_t g, input fld_t e);
        chk({tag, ".rs1"},     32'(g.rs1),     32'(e.rs1));
        chk({tag, ".rs2"},     32'(g.rs2),     32'(e.rs2));
        chk({tag, ".rd"},      32'(g.rd),      32'(e.rd));
        chk({tag, ".imm"},     g.imm,          e.imm);
        chk({tag, ".rd_we"},   32'(g.rd_we),   32'(e.rd_we));
        chk({tag, ".illegal"}, 32'(g.illegal), 32'(e.illegal));
    endtask

    // Reference decode: classify the word, then build the immediate by
    // summing weighted fields with a negative weight for the sign bit.
    function automatic fld_t ref_dec(input logic [31:0] ins, input bit en_m);
        fld_t r;
        byte  k;
        int   v;
        bit   u1, u2, ud;
        r = '0;
        k = "x";
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'h03, 7'h13, 7'h67, 7'h73: k = "I";
                7'h23: k = "S";
                7'h63: k = "B";
                7'h37, 7'h17: k = "U";
                7'h6F: k = "J";
                7'h0F: k = "N";
                7'h33: if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20 ||
                           (en_m && ins[31:25] == 7'h01)) k = "R";
                default: k = "x";
            endcase
        end
        if (k == "x") begin
            r.illegal = 1'b1;
            return r;
        end
        v = 0;
        if (k == "I") v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        if (k == "S") v = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        if (k == "B") v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                          int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (k == "U") v = int'(ins & 32'hFFFF_F000);
        if (k == "J") v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 +
                          int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        r.imm = v;
        u1 = (k == "I") || (k == "S") || (k == "B") || (k == "R");
        u2 = (k == "S") || (k == "B") || (k == "R");
        ud = (k == "I") || (k == "U") || (k == "J") || (k == "R");
        r.rs1   = u1 ? ins[19:15] : 5'd0;
        r.rs2   = u2 ? ins[24:20] : 5'd0;
        r.rd    = ud ? ins[11:7]  : 5'd0;
        r.rd_we = ud && (ins[11:7] != 5'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0]  tab [12];
        logic [31:0] r;
        int unsigned sel;
        tab = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                7'h6F, 7'h33, 7'h0F, 7'h33};
        r   = $urandom;
        sel = $urandom_range(0, 13);
        if (sel < 12) r[6:0] = tab[sel];
        if (r[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    vec_t        tab [13];
    logic [31:0] a_ins, a_addr, t_addr;
    bit          mv;
    logic [31:0] mins, maddr;
    bit          acc;

    initial begin
        // {ins, expected EN_M=0, expected EN_M=1}; fields: rs1 rs2 rd imm rd_we illegal
        tab[0]  = '{32'hFFF00093, '{5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0}, '{5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0}};
        tab[1]  = '{32'h0021A423, '{5'd3, 5'd2, 5'd0, 32'h00000008, 1'b0, 1'b0}, '{5'd3, 5'd2, 5'd0, 32'h00000008, 1'b0, 1'b0}};
        tab[2]  = '{32'hFE208EE3, '{5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0}, '{5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0}};
        tab[3]  = '{32'h000010B7, '{5'd0, 5'd0, 5'd1, 32'h00001000, 1'b1, 1'b0}, '{5'd0, 5'd0, 5'd1, 32'h00001000, 1'b1, 1'b0}};
        tab[4]  = '{32'h00000000, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}};
        tab[5]  = '{32'h02208033, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}, '{5'd1, 5'd2, 5'd0, 32'h00000000, 1'b0, 1'b0}};
        tab[6]  = '{32'h008000EF, '{5'd0, 5'd0, 5'd1, 32'h00000008, 1'b1, 1'b0}, '{5'd0, 5'd0, 5'd1, 32'h00000008, 1'b1, 1'b0}};
        tab[7]  = '{32'h0FF0000F, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}};
        tab[8]  = '{32'h407302B3, '{5'd6, 5'd7, 5'd5, 32'h00000000, 1'b1, 1'b0}, '{5'd6, 5'd7, 5'd5, 32'h00000000, 1'b1, 1'b0}};
        tab[9]  = '{32'h00000001, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}};
        tab[10] = '{32'h0000A003, '{5'd1, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}, '{5'd1, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}};
        tab[11] = '{32'h10000033, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1}};
        tab[12] = '{32'h00000073, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}, '{5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0}};

        // Reset state
        #12;
        chk("rst.valid_o", 32'(valid_o), 32'd0);
        chk("rst.ready_o", 32'(ready_o), 32'd1);
        chk("rst.ins_o", ins_o, 32'd0);
        chk("rst.ins_addr_o", ins_addr_o, 32'd0);
        chk_fld("rst", got0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back-to-back accepts
        for (int i = 0; i < 13; i++) begin
            t_addr     = $urandom;
            ins_i      = tab[i].ins;
            ins_addr_i = t_addr;
            valid_i    = 1'b1;
            ready_i    = 1'b1;
            #1;
            chk("vec.ready_o", 32'(ready_o), 32'd1);
            @(posedge clk); #1;
            chk("vec.valid_o", 32'(valid_o), 32'd1);
            chk("vec.ins_o", ins_o, tab[i].ins);
            chk("vec.ins_addr_o", ins_addr_o, t_addr);
            chk_fld($sformatf("vec%0d.m0", i), got0, tab[i].e0);
            chk_fld($sformatf("vec%0d.m1", i), got1, tab[i].e1);
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk("drain.valid_o", 32'(valid_o), 32'd0);

        // Back-pressure: hold for 5 cycles while the input toggles
        a_ins = 32'h407302B3; a_addr = 32'hA5A5_0004;
        ins_i = a_ins; ins_addr_i = a_addr; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            ins_i = rand_ins(); ins_addr_i = $urandom; valid_i = 1'b1;
            #1;
            chk("bp.ready_o", 32'(ready_o), 32'd0);
            @(posedge clk); #1;
            chk("bp.valid_o", 32'(valid_o), 32'd1);
            chk("bp.ins_o", ins_o, a_ins);
            chk("bp.ins_addr_o", ins_addr_o, a_addr);
            chk_fld("bp", got0, ref_dec(a_ins, 1'b0));
        end
        ins_i = 32'hFFF00093; ins_addr_i = 32'h0000_1000; ready_i = 1'b1;
        #1;
        chk("bp.release.ready_o", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        chk("bp.release.valid_o", 32'(valid_o), 32'd1);
        chk("bp.release.ins_o", ins_o, 32'hFFF00093);
        chk_fld("bp.release", got0, ref_dec(32'hFFF00093, 1'b0));

        // Flush while holding a bundle and offering a new one
        ready_i = 1'b0; ins_i = 32'h0021A423;
        @(posedge clk); #1;
        flush_i = 1'b1; ready_i = 1'b1; valid_i = 1'b1; ins_i = 32'h000010B7;
        @(posedge clk); #1;
        chk("flush.valid_o", 32'(valid_o), 32'd0);
        chk("flush.m1.valid_o", 32'(m1_valid_o), 32'd0);
        flush_i = 1'b0; valid_i = 1'b0;
        @(posedge clk); #1;
        chk("flush.after.valid_o", 32'(valid_o), 32'd0);

        // Reset asserted during a stall
        ins_i = 32'h008000EF; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0; ins_i = 32'h0021A423;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid.valid_o", 32'(valid_o), 32'd0);
        chk("rstmid.ins_o", ins_o, 32'd0);
        chk("rstmid.ins_addr_o", ins_addr_o, 32'd0);
        chk_fld("rstmid", got0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid.ready_o", 32'(ready_o), 32'd1);
        ins_i = 32'hFE208EE3; valid_i = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.first.valid_o", 32'(valid_o), 32'd1);
        chk("rstmid.first.ins_o", ins_o, 32'hFE208EE3);
        valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.drain.valid_o", 32'(valid_o), 32'd0);

        // Randomized traffic against the reference model
        mv = 1'b0; mins = '0; maddr = '0;
        for (int c = 0; c < 400; c++) begin
            valid_i    = ($urandom_range(0, 3) != 0);
            ready_i    = ($urandom_range(0, 2) != 0);
            flush_i    = ($urandom_range(0, 15) == 0);
            ins_i      = rand_ins();
            ins_addr_i = $urandom;
            #1;
            chk("rnd.ready_o", 32'(ready_o), 32'(!mv || ready_i));
            acc = valid_i && (!mv || ready_i) && !flush_i;
            if (flush_i) mv = 1'b0;
            else if (acc) begin
                mv = 1'b1; mins = ins_i; maddr = ins_addr_i;
            end else if (ready_i) mv = 1'b0;
            @(posedge clk); #1;
            chk("rnd.valid_o", 32'(valid_o), 32'(mv));
            chk("rnd.m1.valid_o", 32'(m1_valid_o), 32'(mv));
            if (mv) begin
                chk("rnd.ins_o", ins_o, mins);
                chk("rnd.ins_addr_o", ins_addr_o, maddr);
                chk_fld("rnd.m0", got0, ref_dec(mins, 1'b0));
                chk_fld("rnd.m1", got1, ref_dec(mins, 1'b1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter ADDR_W, default 32, width of instruction address path.
REQ-002 Parameter EN_M, default 0, 1 accepts RV32M encodings (func7=0000001) on OP opcode.
REQ-003 Parameter EN_FLUSH, default 1, 0 ties off flush_i internally.
REQ-004 clk  in  1  sole clock, all state rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ins_i  in  32  fetched instruction; ins_addr_i  in  ADDR_W  its address.
REQ-007 valid_i  in  1  upstream holds valid instruction; ready_o  out  1  stage accepts this cycle.
REQ-008 flush_i  in  1  kill held and incoming instruction.
REQ-009 valid_o  out  1  decoded bundle valid; ready_i  in  1  downstream accepts.
REQ-010 ins_o  out  32; ins_addr_o  out  ADDR_W  registered copies of inputs.
REQ-011 rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register indices, 0 when unused.
REQ-012 imm_o  out  32  sign-extended immediate; rd_we_o  out  1  destination write enable; illegal_o  out  1  illegal encoding flag.

Function
REQ-013 Decode combinational from ins_i, captured into one output register slice; latency exactly 1 cycle accept-to-valid_o.
REQ-014 ready_o = !valid_o || ready_i (combinational, no dependence on valid_i).
REQ-015 Accept when valid_i && ready_o: all outputs load, valid_o=1 next cycle.
REQ-016 valid_o && !ready_i: all outputs hold stable, no bit changes until transfer.
REQ-017 ready_i && valid_o && !accept: valid_o clears next cycle; payload may hold.
REQ-018 flush_i=1: valid_o=0 next cycle regardless of valid_i/ready_i; same-cycle input dropped; flush wins over accept.
REQ-019 Immediate formats, sign bit ins_i[31]: I (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011) = ins[31:20]; S (0100011) = {ins[31:25],ins[11:7]}; B (1100011) = {ins[31],ins[7],ins[30:25],ins[11:8],0}; U (0110111, 0010111) = {ins[31:12],12'b0}; J (1101111) = {ins[31],ins[19:12],ins[20],ins[30:21],0}; R/FENCE/illegal = 0.
REQ-020 rs1 used by I/S/B/R; rs2 used by S/B/R; rd used by I/U/J/R; unused fields output 0.
REQ-021 rd_we_o=1 only when rd used and rd≠0.
REQ-022 illegal_o=1 when ins[1:0]≠11, opcode not listed above, or OP func7 not in {0000000,0100000} (plus 0000001 if EN_M=1); illegal bundles still handshake, all indices/imm 0, rd_we_o=0.
REQ-023 ins_addr_o carries ADDR_W bits unmodified; no arithmetic on address.

Reset
REQ-024 rst_n low: valid_o=0 immediately, all payload outputs 0, ready_o=1 following.
REQ-025 Reset mid-transfer discards held instruction; first accept after release produces valid_o one cycle later.

Structure
REQ-026 Opcode constants, format enum (I,S,B,U,J,R,NONE), func7 constants in shared package decode_pkg, extending existing instruction defines.
REQ-027 One sub-module imm_gen (combinational: ins, format -> imm) instantiated once.

Verification
REQ-028 0xFFF00093 (addi x1,x0,-1), valid_i=1, ready_i=1 -> next cycle valid_o=1, rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF, rd_we=1, illegal=0.
REQ-029 0x0021A423 (sw x2,8(x3)) -> rs1=3, rs2=2, rd=0, imm=0x00000008, rd_we=0.
REQ-030 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, imm=0xFFFFFFFC; 0x000010B7 (lui x1,1) -> imm=0x00001000, rd_we=1.
REQ-031 Back-pressure: valid_o=1, ready_i=0 for 5 cycles, new ins_i toggling -> ready_o=0, outputs unchanged; ready_i=1 -> next instruction loads same cycle.
REQ-032 flush_i=1 with valid_i=1 and valid_o=1 -> valid_o=0 next cycle, no bundle emitted; 0x00000000 -> illegal_o=1; 0x02208033 with EN_M=0 illegal, EN_M=1 legal rd=0 rd_we=0.
REQ-033 rst_n pulled low mid-stall -> valid_o=0 asynchronously, outputs 0, ready_o=1 after release.
